// File: rtl/macflt_seq_if.sv
// Purpose: register bus bundle for the receive-address filter.
//   wb_adr_i [2:0]  register select      wb_dat_i [15:0] write data
//   wb_dat_o [15:0] registered read data wb_cyc_i/wb_stb_i bus cycle and strobe
//   wb_we_i         1 = write            wb_sel_i [1:0]  byte lanes
//   wb_ack_o        acknowledge
interface macflt_seq_if;
  logic [2:0]  wb_adr_i;
  logic [15:0] wb_dat_i;
  logic [15:0] wb_dat_o;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [1:0]  wb_sel_i;
  logic        wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/macflt_seq.sv
// Purpose: receive destination-MAC filter. A DEPTH-entry table of permitted
//   MACs is loaded over the register bus in setup mode and scanned one entry
//   per clock for each received MAC.
// Ports:
//   wb_clk_i, rst_i (synchronous, active high)
//   bus         register bus (slave modport of macflt_seq_if)
//   flt_mode_i  [0] setup mode, [1] promiscuous
//   mac_vld_i   one-cycle pulse qualifying mac_i
//   mac_i       destination MAC, [47:40] = first octet on the wire
//   flt_busy_o  scan in progress
//   flt_done_o  one-cycle result pulse
//   flt_hit_o   accepted, held until the next accepted MAC
//   flt_idx_o   matching entry, 0 on miss or promiscuous
// Build option: define MACFLT_MCAST_EN to add the all-multicast bit (reg 6 bit 15).
module macflt_seq #(
  parameter int unsigned DEPTH = 14,
  parameter int unsigned AW    = 4
) (
  input  logic             wb_clk_i,
  input  logic             rst_i,
  macflt_seq_if.slave      bus,
  input  logic [1:0]       flt_mode_i,
  input  logic             mac_vld_i,
  input  logic [47:0]      mac_i,
  output logic             flt_busy_o,
  output logic             flt_done_o,
  output logic             flt_hit_o,
  output logic [AW-1:0]    flt_idx_o
);
  localparam int unsigned MAC_W = 48;
  localparam int unsigned DAT_W = 16;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      ptr_q, ptr_d;
  logic [MAC_W-1:0]   mac_q, mac_d;
  logic               busy_d, done_d, hit_d, hit_inc;
  logic [AW-1:0]      idx_d;

  logic [MAC_W-1:0]   tbl [DEPTH];
  logic [DEPTH-1:0]   valid_q;
  logic [AW-1:0]      sel_idx_q;
  logic [DAT_W-1:0]   buf1_q, buf2_q, cnt_q;
  logic               acc_q, req, wr_ok, wr_cfg, idx_ok, entry_hit, scan_last, mcast_en;
  logic [MAC_W-1:0]   entry_rd;
  logic [DAT_W-1:0]   rd_c;

  assign req       = bus.wb_cyc_i & bus.wb_stb_i;
  // acc_q marks the cycle before ack; writes land exactly once, on that edge
  assign wr_ok     = acc_q & req & bus.wb_we_i & (bus.wb_sel_i == 2'b11);
  assign wr_cfg    = wr_ok & flt_mode_i[0];
  assign idx_ok    = 32'(sel_idx_q) < DEPTH;
  assign entry_rd  = idx_ok ? tbl[sel_idx_q] : '0;
  assign entry_hit = valid_q[ptr_q] && (tbl[ptr_q] == mac_q);
  assign scan_last = 32'(ptr_q) == (DEPTH - 32'd1);

`ifdef MACFLT_MCAST_EN
  logic mcast_q;
  // All-multicast enable, writable only in setup mode
  always_ff @(posedge wb_clk_i) begin
    if (rst_i) begin
      mcast_q <= 1'b0;
    end else if (wr_cfg && bus.wb_adr_i == 3'd6) begin
      mcast_q <= bus.wb_dat_i[15];
    end
  end
  assign mcast_en = mcast_q;
`else
  assign mcast_en = 1'b0;
`endif

  // Read mux
  always_comb begin
    rd_c = '0;
    case (bus.wb_adr_i)
      3'd0:    rd_c = DAT_W'(sel_idx_q);
      3'd1:    rd_c = entry_rd[15:0];
      3'd2:    rd_c = entry_rd[31:16];
      3'd3:    rd_c = entry_rd[47:32];
      3'd4:    rd_c = DAT_W'(valid_q);
      3'd5:    rd_c = cnt_q;
      3'd6:    rd_c = {mcast_en, 11'd0, flt_hit_o, flt_busy_o, flt_mode_i};
      default: rd_c = '0;
    endcase
  end

  // Bus handshake, configuration registers and hit counter
  always_ff @(posedge wb_clk_i) begin
    if (rst_i) begin
      acc_q        <= 1'b0;
      bus.wb_ack_o <= 1'b0;
      bus.wb_dat_o <= '0;
      sel_idx_q    <= '0;
      buf1_q       <= '0;
      buf2_q       <= '0;
      valid_q      <= '0;
      cnt_q        <= '0;
    end else begin
      acc_q        <= req & ~acc_q & ~bus.wb_ack_o;
      bus.wb_ack_o <= acc_q & req;
      if (acc_q & req) bus.wb_dat_o <= rd_c;
      if (wr_cfg) begin
        case (bus.wb_adr_i)
          3'd0: sel_idx_q <= bus.wb_dat_i[AW-1:0];
          3'd1: buf1_q    <= bus.wb_dat_i;
          3'd2: buf2_q    <= bus.wb_dat_i;
          3'd3: if (idx_ok) valid_q[sel_idx_q] <= 1'b1;
          3'd4: valid_q   <= valid_q & ~bus.wb_dat_i[DEPTH-1:0];
          default: ;
        endcase
      end
      if (wr_ok && bus.wb_adr_i == 3'd5) begin
        cnt_q <= '0;
      end else if (hit_inc && cnt_q != 16'hFFFF) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  // Table storage survives reset
  always_ff @(posedge wb_clk_i) begin
    if (!rst_i && wr_cfg && bus.wb_adr_i == 3'd3 && idx_ok) begin
      tbl[sel_idx_q] <= {bus.wb_dat_i, buf2_q, buf1_q};
    end
  end

  // Filter FSM state and registered outputs
  always_ff @(posedge wb_clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      mac_q      <= '0;
      flt_busy_o <= 1'b0;
      flt_done_o <= 1'b0;
      flt_hit_o  <= 1'b0;
      flt_idx_o  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      mac_q      <= mac_d;
      flt_busy_o <= busy_d;
      flt_done_o <= done_d;
      flt_hit_o  <= hit_d;
      flt_idx_o  <= idx_d;
    end
  end

  // Filter FSM next state
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    mac_d   = mac_q;
    busy_d  = flt_busy_o;
    done_d  = 1'b0;
    hit_d   = flt_hit_o;
    idx_d   = flt_idx_o;
    hit_inc = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mac_vld_i && !flt_mode_i[0]) begin
          mac_d = mac_i;
          ptr_d = '0;
          hit_d = 1'b0;
          idx_d = '0;
          // Promiscuous or all-multicast accepts without consulting the table
          if (flt_mode_i[1] || (mcast_en && mac_i[40])) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hit_d   = 1'b1;
            hit_inc = 1'b1;
          end else begin
            state_d = S_SCAN;
            busy_d  = 1'b1;
          end
        end
      end
      S_SCAN: begin
        if (flt_mode_i[0]) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (entry_hit) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          hit_d   = 1'b1;
          idx_d   = ptr_q;
          hit_inc = 1'b1;
        end else if (scan_last) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_macflt_seq.sv
// Purpose: self-checking bench for macflt_seq with a table-level reference model.
module tb_macflt_seq;
  localparam int unsigned DEPTH = 14;
  localparam int unsigned AW    = 4;
`ifdef MACFLT_MCAST_EN
  localparam bit MCAST = 1'b1;
`else
  localparam bit MCAST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    mode = 2'b00;
  logic          mac_vld = 1'b0;
  logic [47:0]   mac = '0;
  logic          busy, done, hit;
  logic [AW-1:0] idx;

  macflt_seq_if bus();

  macflt_seq #(.DEPTH(DEPTH), .AW(AW)) dut (
    .wb_clk_i   (clk),
    .rst_i      (rst),
    .bus        (bus),
    .flt_mode_i (mode),
    .mac_vld_i  (mac_vld),
    .mac_i      (mac),
    .flt_busy_o (busy),
    .flt_done_o (done),
    .flt_hit_o  (hit),
    .flt_idx_o  (idx)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  logic [47:0]      m_tbl [DEPTH];
  logic [DEPTH-1:0] m_valid = '0;
  logic [AW-1:0]    m_idx = '0;
  logic [15:0]      m_b1 = '0, m_b2 = '0, m_cnt = '0;
  logic             m_mcast = 1'b0;

  // Expected result of the last accepted MAC
  int   cyc = 0;
  int   exp_T = 0, exp_end = 0, exp_idx = 0;
  bit   exp_has_done = 1'b0, exp_scan = 1'b0, exp_hit = 1'b0;
  bit   chk_en = 1'b0;
  logic in_win, e_done, after_d;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Per-cycle compare of the filter outputs against the model
  always @(posedge clk) begin
    #1;
    cyc++;
    if (chk_en) begin
      in_win  = (cyc > exp_T) && (cyc < exp_end);
      e_done  = exp_has_done && (cyc == exp_end);
      after_d = exp_has_done && (cyc >= exp_end);
      check("done", done, e_done);
      check("busy", busy, exp_scan && in_win);
      check("hit",  hit,  after_d ? exp_hit : 1'b0);
      check("idx",  idx,  after_d ? exp_idx : 0);
    end
  end

  task automatic predict(input logic [47:0] a, output int L, output bit h, output int ix);
    L = DEPTH + 1; h = 1'b0; ix = 0;
    if (mode[1] || (m_mcast && a[40])) begin
      L = 1; h = 1'b1;
    end else begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (m_valid[k] && m_tbl[k] == a) begin
          L = k + 2; h = 1'b1; ix = k;
        end
      end
    end
  endtask

  function automatic void mdl_write(input logic [2:0] a, input logic [15:0] d, input logic [1:0] s);
    if (s != 2'b11) return;
    if (a == 3'd5) m_cnt = '0;
    else if (mode[0]) begin
      case (a)
        3'd0: m_idx = d[AW-1:0];
        3'd1: m_b1 = d;
        3'd2: m_b2 = d;
        3'd3: if (m_idx < DEPTH) begin
                m_tbl[m_idx]   = {d, m_b2, m_b1};
                m_valid[m_idx] = 1'b1;
              end
        3'd4: m_valid = m_valid & ~d[DEPTH-1:0];
        3'd6: m_mcast = MCAST & d[15];
        default: ;
      endcase
    end
  endfunction

  function automatic logic [15:0] mdl_read(input logic [2:0] a);
    logic [47:0] e;
    logic        cur_hit;
    e = (m_idx < DEPTH) ? m_tbl[m_idx] : 48'd0;
    cur_hit = exp_has_done ? exp_hit : 1'b0;
    case (a)
      3'd0:    return 16'(m_idx);
      3'd1:    return e[15:0];
      3'd2:    return e[31:16];
      3'd3:    return e[47:32];
      3'd4:    return 16'(m_valid);
      3'd5:    return m_cnt;
      3'd6:    return {m_mcast, 11'd0, cur_hit, 1'b0, mode};
      default: return 16'd0;
    endcase
  endfunction

  // One bus access, starting and ending at a falling edge
  task automatic bus_acc(input logic [2:0] a, input bit we, input logic [15:0] d,
                         input logic [1:0] s, output logic [15:0] r);
    int n;
    n = 0;
    bus.wb_adr_i = a; bus.wb_dat_i = d; bus.wb_we_i = we; bus.wb_sel_i = s;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.wb_ack_o && n < 8);
    check("ack_latency", n, 2);
    r = bus.wb_dat_o;
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d, input logic [1:0] s = 2'b11);
    logic [15:0] r;
    bus_acc(a, 1'b1, d, s, r);
    mdl_write(a, d, s);
  endtask

  task automatic rd_chk(input logic [2:0] a, input string nm, output logic [15:0] r);
    bus_acc(a, 1'b0, 16'd0, 2'b11, r);
    check(nm, r, mdl_read(a));
  endtask

  task automatic launch(input logic [47:0] a, output int L);
    bit h;
    int ix;
    predict(a, L, h, ix);
    exp_T = cyc; exp_end = cyc + L; exp_has_done = 1'b1;
    exp_scan = (L > 1); exp_hit = h; exp_idx = ix;
    if (h && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    mac = a; mac_vld = 1'b1;
    @(negedge clk);
    mac_vld = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (cyc < exp_end + 1 && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) check("idle_timeout", 1, 0);
  endtask

  initial begin
    logic [15:0] r;
    logic [47:0] rmac;
    int L;
    for (int k = 0; k < DEPTH; k++) m_tbl[k] = '0;
    bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_we_i = 1'b0; bus.wb_sel_i = 2'b00;
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hit",  hit,  0);
    check("rst_idx",  idx,  0);
    check("rst_ack",  bus.wb_ack_o, 0);
    check("rst_dat",  bus.wb_dat_o, 0);
    rst = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    rd_chk(3'd4, "rst_valid", r); check("rst_valid_lit", r, 16'h0000);
    rd_chk(3'd5, "rst_cnt", r);   check("rst_cnt_lit", r, 16'h0000);

    // Directed table load
    mode = 2'b01;
    wr(3'd0, 16'd2); wr(3'd1, 16'h1234); wr(3'd2, 16'h5678); wr(3'd3, 16'h9ABC);
    rd_chk(3'd4, "valid", r); check("valid_lit", r, 16'h0004);
    rd_chk(3'd1, "e_lo", r);  check("e_lo_lit", r, 16'h1234);
    rd_chk(3'd2, "e_mid", r); check("e_mid_lit", r, 16'h5678);
    rd_chk(3'd3, "e_hi", r);  check("e_hi_lit", r, 16'h9ABC);
    wr(3'd0, 16'd5, 2'b01);
    rd_chk(3'd0, "idx_partial_sel", r); check("idx_partial_sel_lit", r, 16'd2);

    // Run mode: config writes ignored
    mode = 2'b00;
    wr(3'd0, 16'd7);
    rd_chk(3'd0, "idx_runmode", r); check("idx_runmode_lit", r, 16'd2);

    // Table hit at entry 2
    launch(48'h9ABC_5678_1234, L); check("lat_hit_lit", L, 4);
    wait_idle();
    rd_chk(3'd5, "cnt1", r); check("cnt1_lit", r, 16'h0001);
    rd_chk(3'd6, "stat_hit", r);

    // Miss with a dropped second request during the scan
    launch(48'h1122_3344_5566, L); check("lat_miss_lit", L, 15);
    @(negedge clk); @(negedge clk);
    mac = 48'h9ABC_5678_1234; mac_vld = 1'b1;
    @(negedge clk);
    mac_vld = 1'b0;
    wait_idle();
    rd_chk(3'd5, "cnt_after_drop", r); check("cnt_after_drop_lit", r, 16'h0001);

    // Promiscuous, second request arrives while in DONE
    mode = 2'b10;
    launch(48'hDEAD_BEEF_0000, L); check("lat_prom_lit", L, 1);
    mac = 48'h9ABC_5678_1234; mac_vld = 1'b1;
    @(negedge clk);
    mac_vld = 1'b0;
    wait_idle();
    rd_chk(3'd5, "cnt_prom", r); check("cnt_prom_lit", r, 16'h0002);

    // Setup mode aborts an active scan
    mode = 2'b00;
    launch(48'h0A0B_0C0D_0E0F, L);
    repeat (4) @(negedge clk);
    mode = 2'b01;
    exp_end = cyc + 1; exp_has_done = 1'b0;
    repeat (6) @(negedge clk);
    rd_chk(3'd6, "stat_abort", r);

    // Out-of-range commit and write-1-to-clear
    wr(3'd0, 16'd15); wr(3'd1, 16'h1111); wr(3'd2, 16'h2222); wr(3'd3, 16'h3333);
    rd_chk(3'd4, "valid_oor", r); check("valid_oor_lit", r, 16'h0004);
    rd_chk(3'd1, "e_oor", r);     check("e_oor_lit", r, 16'h0000);
    wr(3'd4, 16'h0004);
    rd_chk(3'd4, "valid_clr", r); check("valid_clr_lit", r, 16'h0000);
    mode = 2'b00;
    launch(48'h9ABC_5678_1234, L); check("lat_cleared_lit", L, 15);
    wait_idle();

    // All-multicast option
    mode = 2'b01;
    wr(3'd6, 16'h8000);
    rd_chk(3'd6, "mcast_reg", r); check("mcast_bit", r[15], MCAST);
    mode = 2'b00;
    launch(48'h0100_5E00_0001, L); check("lat_mcast", L, MCAST ? 1 : 15);
    wait_idle();
    mode = 2'b01;
    wr(3'd6, 16'h0000);

    // Randomized table contents and traffic
    for (int it = 0; it < 6; it++) begin
      mode = 2'b01;
      for (int w = 0; w < 4; w++) begin
        wr(3'd0, 16'($urandom_range(0, 15)));
        wr(3'd1, 16'($urandom)); wr(3'd2, 16'($urandom)); wr(3'd3, 16'($urandom));
        rd_chk(3'($urandom_range(0, 7)), "rand_rd", r);
      end
      if ($urandom_range(0, 2) == 0) wr(3'd4, 16'($urandom));
      rd_chk(3'd4, "rand_valid", r);
      for (int t = 0; t < 8; t++) begin
        mode = ($urandom_range(0, 4) == 0) ? 2'b10 : 2'b00;
        rmac = {16'($urandom), 32'($urandom)};
        if ($urandom_range(0, 1) == 1) rmac = m_tbl[$urandom_range(0, DEPTH - 1)];
        launch(rmac, L);
        wait_idle();
      end
      mode = 2'b00;
      rd_chk(3'd5, "rand_cnt", r);
    end

    // Hit counter clear works in run mode
    wr(3'd5, 16'h1234);
    rd_chk(3'd5, "cnt_clr", r); check("cnt_clr_lit", r, 16'h0000);

    // Reset in the middle of a scan
    launch(48'hFFFF_0000_FFFF, L);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    exp_end = cyc + 1; exp_has_done = 1'b0; exp_scan = 1'b0;
    m_valid = '0; m_idx = '0; m_cnt = '0; m_mcast = 1'b0; m_b1 = '0; m_b2 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rd_chk(3'd4, "valid_after_rst", r); check("valid_after_rst_lit", r, 16'h0000);
    rd_chk(3'd7, "reg7", r);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
